scanchain_prog_ctrl: RTL and testbench
======================================

# scanchain_prog_ctrl

Sequencing controller that programs a scanchain of `mdff`-based configuration cells from a word-wide bitstream stream. Accepts bitstream words over a valid/ready handshake, serialises them into `CFG_WIDTH`-bit chunks on the chain's shift interface, counts the configured chain length, and issues a single commit pulse when the whole chain is loaded. Sits between the bitstream loader (host/DMA side) and the top-level scanchain of the fabric.

## Interface
Parameters:
- `CFG_WIDTH`, 1: chain bits shifted per cycle; divides `WORD_WIDTH`.
- `WORD_WIDTH`, 32: bitstream word width.
- `LEN_WIDTH`, 24: width of chain-length counter (max chain = 2^LEN_WIDTH-1 bits).

Ports:
- `clk`  in  1  configuration clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin programming; sampled only in IDLE.
- `abort`  in  1  cancel programming; returns to IDLE without commit.
- `chain_len`  in  LEN_WIDTH  chain length in bits; latched on accepted `start`; must be a multiple of `CFG_WIDTH`.
- `bs_data`  in  WORD_WIDTH  bitstream word.
- `bs_valid`  in  1  `bs_data` valid.
- `bs_ready`  out  1  controller accepts a word this cycle.
- `cfg_e`  out  1  chain shift enable.
- `cfg_i`  out  CFG_WIDTH  chain shift-in data.
- `cfg_we`  out  1  one-cycle commit pulse after final shift.
- `busy`  out  1  state is not IDLE/DONE.
- `done`  out  1  programming complete; held until next `start` or `abort`.

## Operation
- States: IDLE, LOAD, SHIFT, COMMIT, DONE.
- IDLE: `start`=1 latches `chain_len` into `remaining`; if `chain_len`=0 go DONE directly (no `cfg_e`, no `cfg_we`), else go LOAD.
- LOAD: `bs_ready`=1; on `bs_valid`&&`bs_ready` capture word into shift register, go SHIFT.
- SHIFT: `cfg_e`=1, `cfg_i` = top `CFG_WIDTH` bits of shift register (MSB-first); shift left by `CFG_WIDTH`, `remaining -= CFG_WIDTH`. When `remaining` reaches 0 -> COMMIT; else when all `WORD_WIDTH/CFG_WIDTH` chunks of the word are shifted -> LOAD.
- Final word partial: only `remaining` bits shifted; leftover low bits discarded.
- COMMIT: `cfg_we`=1 for exactly one cycle, `cfg_e`=0 -> DONE.
- DONE: `done`=1; `start` restarts as from IDLE (clears `done` next cycle).
- `abort`=1 in any state -> IDLE next cycle; `cfg_e`, `cfg_we`, `bs_ready` low from that cycle's next edge; no commit. `abort` has priority over `start` and `bs_valid`.
- `start` outside IDLE/DONE ignored.
- `bs_ready`=0 outside LOAD; words are never accepted during SHIFT (no overlap).

## Timing
- Reset (`rst_n`=0, async): state IDLE; `bs_ready`, `cfg_e`, `cfg_we`, `busy`, `done` = 0; `cfg_i` = 0; counters and shift register cleared. Reset mid-programming discards progress, no commit.
- All outputs registered or decoded from registered state only; no combinational path from `bs_valid` to `bs_ready`.
- `start` accepted at edge t -> LOAD (`bs_ready`=1) in cycle t+1.
- Word accepted at edge t -> first `cfg_e` cycle t+1.
- Full word costs `WORD_WIDTH/CFG_WIDTH` shift cycles + ≥1 LOAD cycle.
- Last shift at cycle t -> `cfg_we` at t+1 -> `done` at t+2.
- `bs_valid` low in LOAD: stall indefinitely, `cfg_e`=0.

## Structure
- Shared package `scanchain_pkg`: state enum `scanchain_prog_state_t` (IDLE, LOAD, SHIFT, COMMIT, DONE) and localparam `CHUNKS_PER_WORD = WORD_WIDTH/CFG_WIDTH`.
- One natural sub-module: `scanchain_word_serializer` (word load, MSB-first `CFG_WIDTH` chunk shift, chunk counter, last-chunk flag). FSM and length counter stay in top.

## Test plan
- W=32, C=1, `chain_len`=40, words 0xA5A5A5A5, 0xFF000000 always valid -> 40 `cfg_e` cycles, `cfg_i` = 1010…(32 bits) then 11111111, one `cfg_we` pulse, `done`=1; low 24 bits of word 2 never shifted.
- C=4, `chain_len`=32, word 0x12345678 -> 8 `cfg_e` cycles with `cfg_i` 1,2,3,4,5,6,7,8, then `cfg_we`, then `done`.
- `bs_valid` deasserted 5 cycles between words -> `cfg_e` low during stall, `bs_ready` high throughout, shifted data identical to no-stall run.
- `abort` asserted mid-SHIFT after 10 bits -> IDLE next cycle, `cfg_e`=0, no `cfg_we`, `done`=0; subsequent `start` programs full chain correctly.
- `chain_len`=0 -> `done`=1 one cycle after `start`, zero `cfg_e`/`cfg_we` cycles, `bs_ready` never high.
- `rst_n` pulsed low mid-SHIFT -> all outputs 0 immediately (asynchronously); `start` ignored while busy otherwise.

Source files
------------

// File: rtl/scanchain_pkg.sv
// scanchain_pkg: FSM state type and word/chunk sizing shared by the scanchain programmer.
package scanchain_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, COMMIT, DONE} scanchain_prog_state_t;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_CFG_WIDTH = 1;
  localparam int CHUNKS_PER_WORD = DEF_WORD_WIDTH / DEF_CFG_WIDTH;
  function automatic int chunks_per_word(input int word_width, input int cfg_width);
    return word_width / cfg_width;
  endfunction
endpackage

// File: rtl/scanchain_word_serializer.sv
// scanchain_word_serializer: holds one bitstream word and emits it MSB-first in CFG_WIDTH chunks.
module scanchain_word_serializer
  import scanchain_pkg::*;
#(
  parameter int CFG_WIDTH = DEF_CFG_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int CHUNKS = CHUNKS_PER_WORD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [CFG_WIDTH-1:0]  chunk,
  output logic                  last_chunk
);
  localparam int CW = $clog2(CHUNKS) + 1;
  logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sreg_d = load ? data_in : shift ? sreg_q << CFG_WIDTH : sreg_q;
    cnt_d = load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q <= cnt_d;
    end
  end
  assign chunk = sreg_q[WORD_WIDTH-1 -: CFG_WIDTH];
  assign last_chunk = cnt_q == CW'(CHUNKS - 1);
endmodule

// File: rtl/scanchain_prog_ctrl.sv
// scanchain_prog_ctrl: streams bitstream words into a configuration scanchain and commits it once
// the programmed chain length has been shifted.
module scanchain_prog_ctrl
  import scanchain_pkg::*;
#(
  parameter int CFG_WIDTH = 1,
  parameter int WORD_WIDTH = 32,
  parameter int LEN_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  chain_len,
  input  logic [WORD_WIDTH-1:0] bs_data,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  output logic                  cfg_e,
  output logic [CFG_WIDTH-1:0]  cfg_i,
  output logic                  cfg_we,
  output logic                  busy,
  output logic                  done
);
  localparam logic [LEN_WIDTH-1:0] STEP = LEN_WIDTH'(CFG_WIDTH);
  scanchain_prog_state_t state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic load, shift, last_chunk;
  logic [CFG_WIDTH-1:0] chunk;
  scanchain_word_serializer #(
    .CFG_WIDTH(CFG_WIDTH),
    .WORD_WIDTH(WORD_WIDTH),
    .CHUNKS(chunks_per_word(WORD_WIDTH, CFG_WIDTH))
  ) u_ser (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .shift(shift),
    .data_in(bs_data),
    .chunk(chunk),
    .last_chunk(last_chunk)
  );
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    load = 1'b0;
    shift = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        rem_d = chain_len;
        state_d = (chain_len == '0) ? DONE : LOAD;
      end
      LOAD: if (bs_valid) begin
        load = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        rem_d = (rem_q <= STEP) ? '0 : rem_q - STEP;
        state_d = (rem_q <= STEP) ? COMMIT : last_chunk ? LOAD : SHIFT;
      end
      COMMIT: state_d = DONE;
      default: state_d = IDLE;
    endcase
    // abort outranks every other request, including a same-cycle start or word
    if (abort) begin
      state_d = IDLE;
      rem_d = '0;
      load = 1'b0;
      shift = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
    end
  end
  assign bs_ready = state_q == LOAD;
  assign cfg_e = state_q == SHIFT;
  assign cfg_i = cfg_e ? chunk : '0;
  assign cfg_we = state_q == COMMIT;
  assign busy = state_q inside {LOAD, SHIFT, COMMIT};
  assign done = state_q == DONE;
endmodule

// File: tb/tb_scanchain_prog_ctrl.sv
// tb_scanchain_prog_ctrl: table-driven and randomized checks of the scanchain programmer against
// a bitstream model (chain contents = words concatenated MSB-first, truncated to chain_len).
module tb_scanchain_prog_ctrl;
  logic clk = 0, rst_n = 1, start = 0, abort = 0, bs_valid = 0;
  logic [23:0] chain_len = '0;
  logic [31:0] bs_data = '0;
  logic bs_ready, cfg_e, cfg_we, busy, done;
  logic [0:0] cfg_i;
  logic s4_start = 0, s4_valid = 0;
  logic [23:0] s4_len = '0;
  logic [31:0] s4_data = '0;
  logic s4_ready, s4_e, s4_we, s4_busy, s4_done;
  logic [3:0] s4_i;
  int checks = 0, errors = 0;
  int cyc = 0, last_e = 0, we_cyc = 0, done_cyc = 0, we_cnt = 0, e_cnt = 0;
  logic prev_done = 0;
  logic got[$];

  typedef struct {
    int len;
    int gap;
    bit poke;
    logic [31:0] w0;
    logic [31:0] w1;
    int exp_sh;
    int exp_we;
  } vec_t;

  always #5 clk = ~clk;

  scanchain_prog_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chain_len(chain_len),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready), .cfg_e(cfg_e),
    .cfg_i(cfg_i), .cfg_we(cfg_we), .busy(busy), .done(done)
  );

  scanchain_prog_ctrl #(.CFG_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .abort(1'b0), .chain_len(s4_len),
    .bs_data(s4_data), .bs_valid(s4_valid), .bs_ready(s4_ready), .cfg_e(s4_e),
    .cfg_i(s4_i), .cfg_we(s4_we), .busy(s4_busy), .done(s4_done)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (cfg_e) begin
        got.push_back(cfg_i[0]);
        e_cnt++;
        last_e = cyc;
      end
      if (cfg_we) begin
        we_cnt++;
        we_cyc = cyc;
      end
      if (done && !prev_done) done_cyc = cyc;
      check("ready_vs_shift_exclusive", {30'd0, bs_ready, cfg_e} & 32'h3, bs_ready ? 32'h2 : {31'd0, cfg_e});
    end
    prev_done = done;
  end

  task automatic wait_ready(input string nm);
    int t = 0;
    while (!bs_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bs_ready) check(nm, 0, 1);
  endtask

  task automatic run_prog(input vec_t v);
    logic [31:0] words[$];
    logic exp_bits[$];
    int nw, b0, e0, wc0, t;
    nw = (v.len + 31) / 32;
    for (int i = 0; i < nw; i++) words.push_back(i == 0 ? v.w0 : i == 1 ? v.w1 : $urandom());
    for (int i = 0; i < v.len; i++) exp_bits.push_back(words[i / 32][31 - (i % 32)]);
    b0 = got.size();
    e0 = e_cnt;
    wc0 = we_cnt;
    @(negedge clk);
    start = 1;
    chain_len = 24'(v.len);
    @(negedge clk);
    start = 0;
    chain_len = 24'($urandom());
    if (v.len == 0) begin
      check("zero_len_done_next_cycle", {31'd0, done}, 1);
      check("zero_len_no_ready", {31'd0, bs_ready}, 0);
    end else begin
      check("start_to_load_ready", {31'd0, bs_ready}, 1);
      check("start_to_load_busy", {31'd0, busy}, 1);
    end
    for (int i = 0; i < nw; i++) begin
      wait_ready("wait_ready_timeout");
      for (int g = 0; g < v.gap; g++) begin
        check("stall_ready_high", {31'd0, bs_ready}, 1);
        check("stall_no_shift", {31'd0, cfg_e}, 0);
        if (v.poke && i == 0 && g == 0) begin
          start = 1;
          chain_len = 24'd8;
        end
        @(negedge clk);
        start = 0;
      end
      bs_valid = 1;
      bs_data = words[i];
      @(negedge clk);
      bs_valid = 0;
      bs_data = $urandom();
    end
    t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("done_reached", {31'd0, done}, 1);
    check("shift_cycles", e_cnt - e0, v.exp_sh);
    check("commit_pulses", we_cnt - wc0, v.exp_we);
    for (int i = 0; i < v.len; i++)
      if (got.size() > b0 + i && got[b0 + i] !== exp_bits[i]) begin
        check($sformatf("chain_bit_%0d", i), {31'd0, got[b0 + i]}, {31'd0, exp_bits[i]});
        break;
      end
    check("chain_bits_total", got.size() - b0, v.len);
    if (v.len > 0) begin
      check("last_shift_to_commit", we_cyc - last_e, 1);
      check("commit_to_done", done_cyc - we_cyc, 1);
    end
  endtask

  vec_t vecs[6];
  vec_t rv;
  int n, we0;
  logic [3:0] nib[$];

  initial begin
    vecs[0] = '{40, 0, 0, 32'hA5A5A5A5, 32'hFF000000, 40, 1};
    vecs[1] = '{40, 5, 0, 32'hA5A5A5A5, 32'hFF000000, 40, 1};
    vecs[2] = '{0, 0, 0, 32'h0, 32'h0, 0, 0};
    vecs[3] = '{32, 2, 1, 32'hDEADBEEF, 32'h0, 32, 1};
    vecs[4] = '{1, 0, 0, 32'h80000000, 32'h0, 1, 1};
    vecs[5] = '{65, 1, 0, 32'h12345678, 32'h9ABCDEF0, 65, 1};
    #1 rst_n = 0;
    #1;
    check("reset_outputs", {26'd0, bs_ready, cfg_e, cfg_i, cfg_we, busy, done}, 0);
    @(negedge clk);
    rst_n = 1;

    // CFG_WIDTH=4 instance: 0x12345678 comes out as nibbles 1..8
    s4_start = 1;
    s4_len = 24'd32;
    s4_valid = 1;
    s4_data = 32'h12345678;
    @(negedge clk);
    s4_start = 0;
    n = 0;
    for (int t = 0; t < 40 && !s4_done; t++) begin
      @(negedge clk);
      if (s4_e) nib.push_back(s4_i);
      if (s4_we) n++;
    end
    s4_valid = 0;
    check("c4_shift_cycles", nib.size(), 8);
    for (int i = 0; i < nib.size() && i < 8; i++) check($sformatf("c4_nibble_%0d", i), {28'd0, nib[i]}, i + 1);
    check("c4_commit_pulses", n, 1);
    check("c4_done", {31'd0, s4_done}, 1);

    foreach (vecs[i]) run_prog(vecs[i]);

    start = 1;
    abort = 1;
    chain_len = 24'd40;
    @(negedge clk);
    start = 0;
    abort = 0;
    check("abort_beats_start", {30'd0, busy, done}, 0);

    start = 1;
    @(negedge clk);
    start = 0;
    wait_ready("abort_setup_ready");
    bs_valid = 1;
    bs_data = $urandom();
    @(negedge clk);
    bs_valid = 0;
    n = 0;
    for (int t = 0; t < 100 && n < 10; t++) begin
      if (cfg_e) n++;
      if (n < 10) @(negedge clk);
    end
    we0 = we_cnt;
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_state", {28'd0, cfg_e, busy, done, bs_ready}, 0);
    repeat (5) @(negedge clk);
    check("abort_no_commit", we_cnt - we0, 0);
    check("abort_stays_idle", {30'd0, busy, done}, 0);
    run_prog('{40, 0, 0, 32'hCAFEF00D, 32'h5A000000, 40, 1});

    start = 1;
    chain_len = 24'd40;
    @(negedge clk);
    start = 0;
    wait_ready("reset_setup_ready");
    bs_valid = 1;
    bs_data = $urandom();
    @(negedge clk);
    bs_valid = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("async_reset_mid_shift", {26'd0, bs_ready, cfg_e, cfg_i, cfg_we, busy, done}, 0);
    @(negedge clk);
    rst_n = 1;
    run_prog('{40, 1, 1, 32'h0F0F1234, 32'hE7000000, 40, 1});

    for (int k = 0; k < 15; k++) begin
      rv.len = $urandom_range(0, 100);
      rv.gap = $urandom_range(0, 3);
      rv.poke = 1'($urandom_range(0, 1));
      rv.w0 = $urandom();
      rv.w1 = $urandom();
      rv.exp_sh = rv.len;
      rv.exp_we = rv.len != 0 ? 1 : 0;
      run_prog(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
